// File: rtl/cart_irq_ctrl.sv
// ---------------------------------------------------------------------------
// cart_irq_ctrl
// Cartridge interrupt controller. It drives the active-low nCartInt line to
// the console. It synchronises NUM_SRC asynchronous event inputs and latches
// their rising edges into pending bits. It also provides a prescaled 16-bit
// interval timer whose expiry sets pending[7]. nCartInt is asserted (low)
// while any enabled bit is pending. The I/O decoder writes registers through
// one-cycle strobes, and ReadData returns register RegAddr combinationally.
//
// Ports
//   SClk       in   cartridge clock, all state changes on posedge
//   nReset     in   asynchronous active-low reset
//   RegWrite   in   one-cycle register write strobe
//   RegAddr    in   [2:0] local register index
//   WriteData  in   [7:0] write data, valid with RegWrite
//   ReadData   out  [7:0] combinational read of register RegAddr
//   SrcEvent   in   [NUM_SRC-1:0] asynchronous level event inputs
//   nCartInt   out  registered active-low interrupt
//   TimerRun   out  timer currently counting
//
// Register map
//   0 ENABLE     [NUM_SRC-1:0] source enables, [7] timer enable
//   1 PENDING    read pending, write 1 to clear (a new event wins over a clear)
//   2 RELOAD_LO  3 RELOAD_HI
//   4 TCTRL      [0] run, [1] repeat
//   5 COUNT_LO   6 COUNT_HI (read only)
//   7 reads 0
// ---------------------------------------------------------------------------
module cart_irq_ctrl #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE    = 384
) (
  input  logic               SClk,
  input  logic               nReset,
  input  logic               RegWrite,
  input  logic [2:0]         RegAddr,
  input  logic [7:0]         WriteData,
  output logic [7:0]         ReadData,
  input  logic [NUM_SRC-1:0] SrcEvent,
  output logic               nCartInt,
  output logic               TimerRun
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  // Only the implemented source bits and the timer bit exist, so every other
  // bit of ENABLE and PENDING reads 0.
  localparam logic [7:0] SRC_MASK  = 8'((9'd1 << NUM_SRC) - 9'd1);
  localparam logic [7:0] IMPL_MASK = SRC_MASK | 8'h80;

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q, sync_d;
  logic [NUM_SRC-1:0] prev_q, prev_d;
  logic [7:0]         enable_q, enable_d;
  logic [7:0]         pending_q, pending_d;
  logic [15:0]        reload_q, reload_d;
  logic [15:0]        count_q, count_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               run_q, run_d;
  logic               rpt_q, rpt_d;
  logic               nint_q, nint_d;

  logic [NUM_SRC-1:0] src_evt;
  logic               timer_hit;
  logic               wr_enable, wr_pending, wr_rld_lo, wr_rld_hi, wr_tctrl;

  assign wr_enable  = RegWrite && (RegAddr == 3'd0);
  assign wr_pending = RegWrite && (RegAddr == 3'd1);
  assign wr_rld_lo  = RegWrite && (RegAddr == 3'd2);
  assign wr_rld_hi  = RegWrite && (RegAddr == 3'd3);
  assign wr_tctrl   = RegWrite && (RegAddr == 3'd4);

  // Synchroniser chain plus one delay flop. A source held high across reset
  // release therefore produces exactly one rising edge once the chain fills.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], SrcEvent};
    prev_d  = sync_q[SYNC_STAGES-1];
    src_evt = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  // Interval timer. The prescaler wraps every PRESCALE cycles and then
  // decrements the count. Reaching zero raises timer_hit. In repeat mode the
  // count reloads on that same edge, so the period is exactly
  // RELOAD*PRESCALE cycles. A TCTRL write overrides the free-running update.
  always_comb begin
    presc_d   = presc_q;
    count_d   = count_q;
    run_d     = run_q;
    rpt_d     = rpt_q;
    timer_hit = 1'b0;
    if (run_q) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        count_d = count_q - 16'd1;
        if (count_q == 16'd1) begin
          timer_hit = 1'b1;
          // With a zero reload there is nothing to count, so the timer stops.
          if (rpt_q && (reload_q != 16'd0)) begin
            count_d = reload_q;
          end else begin
            run_d = 1'b0;
          end
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    if (wr_tctrl) begin
      rpt_d = WriteData[1];
      if (WriteData[0] && (reload_q != 16'd0)) begin
        count_d = reload_q;
        presc_d = '0;
        run_d   = 1'b1;
      end else begin
        run_d = 1'b0;
      end
    end
  end

  // Register file. In PENDING the clear is applied first and the new events
  // are ORed in afterwards, so an event on the same cycle survives a clear.
  always_comb begin
    enable_d  = enable_q;
    reload_d  = reload_q;
    pending_d = pending_q;
    if (wr_enable) begin
      enable_d = WriteData & IMPL_MASK;
    end
    if (wr_rld_lo) begin
      reload_d[7:0] = WriteData;
    end
    if (wr_rld_hi) begin
      reload_d[15:8] = WriteData;
    end
    if (wr_pending) begin
      pending_d = pending_q & ~WriteData;
    end
    pending_d = (pending_d | 8'(src_evt) | {timer_hit, 7'b0}) & IMPL_MASK;
    nint_d    = ~|(pending_q & enable_q);
  end

  always_ff @(posedge SClk or negedge nReset) begin
    if (!nReset) begin
      sync_q    <= '0;
      prev_q    <= '0;
      enable_q  <= '0;
      pending_q <= '0;
      reload_q  <= '0;
      count_q   <= '0;
      presc_q   <= '0;
      run_q     <= 1'b0;
      rpt_q     <= 1'b0;
      nint_q    <= 1'b1;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      reload_q  <= reload_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      run_q     <= run_d;
      rpt_q     <= rpt_d;
      nint_q    <= nint_d;
    end
  end

  always_comb begin
    ReadData = 8'h00;
    case (RegAddr)
      3'd0:    ReadData = enable_q;
      3'd1:    ReadData = pending_q;
      3'd2:    ReadData = reload_q[7:0];
      3'd3:    ReadData = reload_q[15:8];
      3'd4:    ReadData = {6'b0, rpt_q, run_q};
      3'd5:    ReadData = count_q[7:0];
      3'd6:    ReadData = count_q[15:8];
      default: ReadData = 8'h00;
    endcase
  end

  assign nCartInt = nint_q;
  assign TimerRun = run_q;

endmodule

// File: tb/tb_cart_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cart_irq_ctrl
// Directed bench for cart_irq_ctrl with PRESCALE=4. The stimulus process
// pushes each expected observation, stamped with the cycle on which it must
// hold, into a scoreboard queue. A monitor on the falling edge pops the
// entries for the current cycle and compares them with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_cart_irq_ctrl;

  localparam int NUM_SRC  = 4;
  localparam int PRESCALE = 4;

  localparam int SEL_NINT = 0;
  localparam int SEL_RUN  = 1;
  localparam int SEL_READ = 2;

  logic               SClk = 1'b0;
  logic               nReset;
  logic               RegWrite;
  logic [2:0]         RegAddr;
  logic [7:0]         WriteData;
  logic [7:0]         ReadData;
  logic [NUM_SRC-1:0] SrcEvent;
  logic               nCartInt;
  logic               TimerRun;

  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  cart_irq_ctrl #(
    .NUM_SRC    (NUM_SRC),
    .SYNC_STAGES(2),
    .PRESCALE   (PRESCALE)
  ) dut (
    .SClk     (SClk),
    .nReset   (nReset),
    .RegWrite (RegWrite),
    .RegAddr  (RegAddr),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .SrcEvent (SrcEvent),
    .nCartInt (nCartInt),
    .TimerRun (TimerRun)
  );

  always #5 SClk = ~SClk;

  always @(posedge SClk) cyc <= cyc + 1;

  // Monitor: consume every scoreboard entry due on this cycle.
  always @(negedge SClk) begin
    exp_t       e;
    logic [7:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("[TB] FAIL %s: observation missed (due cycle %0d, now %0d)", e.name, e.cyc, cyc);
      end else begin
        case (e.sel)
          SEL_NINT: act = {7'b0, nCartInt};
          SEL_RUN:  act = {7'b0, TimerRun};
          default:  act = ReadData;
        endcase
        if (act !== e.exp) begin
          errors++;
          $display("[TB] FAIL %s: got 0x%02h expected 0x%02h (cycle %0d)", e.name, act, e.exp, cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge SClk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic applyStimulus(input logic [2:0] addr, input logic [7:0] data);
    RegWrite  = 1'b1;
    RegAddr   = addr;
    WriteData = data;
    tick();
    RegWrite  = 1'b0;
    WriteData = 8'h00;
  endtask

  task automatic checkOutput(input string name, input int sel, input logic [2:0] addr,
                             input logic [7:0] exp);
    exp_t e;
    if (sel == SEL_READ) RegAddr = addr;
    e.cyc  = cyc;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nReset    = 1'b0;
    RegWrite  = 1'b0;
    RegAddr   = 3'd0;
    WriteData = 8'h00;
    SrcEvent  = '0;
    tick();

    // Reset state: interrupt idle, all registers read 0.
    checkOutput("rst_nint", SEL_NINT, 3'd0, 8'h01);
    checkOutput("rst_run", SEL_RUN, 3'd0, 8'h00);
    checkOutput("rst_reg0", SEL_READ, 3'd0, 8'h00);
    tick();
    for (int a = 1; a < 8; a++) begin
      checkOutput($sformatf("rst_reg%0d", a), SEL_READ, 3'(a), 8'h00);
      tick();
    end
    nReset = 1'b1;
    checkOutput("rel_nint", SEL_NINT, 3'd0, 8'h01);
    tick();

    // Source 0 enabled: pending after 3 edges, interrupt one edge later.
    applyStimulus(3'd0, 8'h01);
    SrcEvent[0] = 1'b1;
    idle(2);
    checkOutput("src0_pend_early", SEL_READ, 3'd1, 8'h00);
    tick();
    checkOutput("src0_pend", SEL_READ, 3'd1, 8'h01);
    checkOutput("src0_nint_early", SEL_NINT, 3'd0, 8'h01);
    tick();
    checkOutput("src0_nint", SEL_NINT, 3'd0, 8'h00);
    applyStimulus(3'd1, 8'h01);
    checkOutput("src0_w1c", SEL_READ, 3'd1, 8'h00);
    tick();
    checkOutput("src0_nint_clr", SEL_NINT, 3'd0, 8'h01);

    // Masked source 1 and the W1C/set race.
    applyStimulus(3'd0, 8'h00);
    SrcEvent[1] = 1'b1;
    idle(3);
    checkOutput("src1_pend", SEL_READ, 3'd1, 8'h02);
    tick();
    checkOutput("src1_nint_masked", SEL_NINT, 3'd0, 8'h01);
    SrcEvent[1] = 1'b0;
    idle(4);
    SrcEvent[1] = 1'b1;
    tick();
    checkOutput("race_pend_before", SEL_READ, 3'd1, 8'h02);
    tick();
    applyStimulus(3'd1, 8'h02);
    checkOutput("race_set_wins", SEL_READ, 3'd1, 8'h02);
    tick();
    applyStimulus(3'd1, 8'h02);
    checkOutput("race_cleared", SEL_READ, 3'd1, 8'h00);
    tick();

    // One-shot timer: RELOAD=3, PRESCALE=4 -> hit 12 cycles after the write.
    applyStimulus(3'd2, 8'h03);
    applyStimulus(3'd3, 8'h00);
    applyStimulus(3'd4, 8'h01);
    checkOutput("os_cnt_start", SEL_READ, 3'd5, 8'h03);
    checkOutput("os_run_on", SEL_RUN, 3'd0, 8'h01);
    idle(4);
    checkOutput("os_cnt_dec", SEL_READ, 3'd5, 8'h02);
    idle(7);
    checkOutput("os_pend_early", SEL_READ, 3'd1, 8'h00);
    tick();
    checkOutput("os_pend_hit", SEL_READ, 3'd1, 8'h80);
    checkOutput("os_run_off", SEL_RUN, 3'd0, 8'h00);
    tick();
    checkOutput("os_cnt_zero", SEL_READ, 3'd5, 8'h00);
    checkOutput("os_nint_masked", SEL_NINT, 3'd0, 8'h01);
    tick();
    checkOutput("os_cnt_hi_zero", SEL_READ, 3'd6, 8'h00);
    tick();
    applyStimulus(3'd1, 8'h80);

    // Repeat timer: RELOAD=2 -> every 8 cycles; RELOAD=5 applies at next reload.
    applyStimulus(3'd0, 8'h80);
    applyStimulus(3'd2, 8'h02);
    applyStimulus(3'd4, 8'h03);
    checkOutput("rp_run", SEL_RUN, 3'd0, 8'h01);
    idle(7);
    checkOutput("rp_pend_early", SEL_READ, 3'd1, 8'h00);
    tick();
    checkOutput("rp_pend_hit1", SEL_READ, 3'd1, 8'h80);
    tick();
    checkOutput("rp_nint", SEL_NINT, 3'd0, 8'h00);
    applyStimulus(3'd1, 8'h80);
    checkOutput("rp_pend_clr", SEL_READ, 3'd1, 8'h00);
    tick();
    checkOutput("rp_nint_clr", SEL_NINT, 3'd0, 8'h01);
    applyStimulus(3'd2, 8'h05);
    idle(3);
    checkOutput("rp_pend_early2", SEL_READ, 3'd1, 8'h00);
    tick();
    checkOutput("rp_pend_hit2", SEL_READ, 3'd1, 8'h80);
    tick();
    checkOutput("rp_cnt_reload5", SEL_READ, 3'd5, 8'h05);
    tick();
    applyStimulus(3'd1, 8'h80);
    idle(16);
    checkOutput("rp_pend_early3", SEL_READ, 3'd1, 8'h00);
    tick();
    checkOutput("rp_pend_hit3", SEL_READ, 3'd1, 8'h80);
    tick();

    // Stop holds the count; run with RELOAD=0 never starts.
    applyStimulus(3'd4, 8'h00);
    checkOutput("stop_run", SEL_RUN, 3'd0, 8'h00);
    tick();
    checkOutput("stop_cnt_hold", SEL_READ, 3'd5, 8'h05);
    tick();
    applyStimulus(3'd2, 8'h00);
    applyStimulus(3'd3, 8'h00);
    applyStimulus(3'd4, 8'h03);
    checkOutput("rl0_run", SEL_RUN, 3'd0, 8'h00);
    tick();
    checkOutput("rl0_tctrl", SEL_READ, 3'd4, 8'h02);
    tick();
    checkOutput("rl0_run_later", SEL_RUN, 3'd0, 8'h00);
    tick();

    // Reset in the middle of a count.
    applyStimulus(3'd2, 8'h03);
    applyStimulus(3'd4, 8'h01);
    idle(2);
    checkOutput("mr_nint_before", SEL_NINT, 3'd0, 8'h00);
    checkOutput("mr_cnt_before", SEL_READ, 3'd5, 8'h03);
    tick();
    nReset = 1'b0;
    checkOutput("mr_cnt", SEL_READ, 3'd5, 8'h00);
    checkOutput("mr_nint", SEL_NINT, 3'd0, 8'h01);
    tick();
    checkOutput("mr_pend", SEL_READ, 3'd1, 8'h00);
    checkOutput("mr_run", SEL_RUN, 3'd0, 8'h00);
    tick();
    checkOutput("mr_enable", SEL_READ, 3'd0, 8'h00);
    tick();

    // Sources 0 and 1 are held high across release: exactly one event each.
    nReset = 1'b1;
    idle(2);
    checkOutput("hold_pend_early", SEL_READ, 3'd1, 8'h00);
    tick();
    checkOutput("hold_pend", SEL_READ, 3'd1, 8'h03);
    tick();
    applyStimulus(3'd1, 8'h03);
    idle(4);
    checkOutput("hold_one_event", SEL_READ, 3'd1, 8'h00);
    checkOutput("hold_nint", SEL_NINT, 3'd0, 8'h01);
    tick();
    idle(2);

    if (sb.size() != 0) begin
      errors += sb.size();
      $display("[TB] FAIL scoreboard: %0d observations left unchecked, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
